// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the DDR audio arbiter.
// FSM state, requester ID type, default parameters.
package ddr_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_e;

  // 0 = playback, 1 = capture
  typedef logic req_id_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_OUT = 4;

endpackage

// File: rtl/ddr_arb_id_fifo.sv
// Requester-ID FIFO tracking outstanding reads in issue order.
// Ports: clk, reset, push/din, pop/dout, full, empty, count.
module ddr_arb_id_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  req_id_t                  din,
  input  logic                     pop,
  output req_id_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  req_id_t         mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/ddr_audio_arb.sv
// Two-requester (playback/capture) arbiter onto one Avalon-MM master.
// Ports: clk, reset, rq0/rq1 cmd+ready, rsp0/rsp1_valid, rsp_data,
// avm_* master, err_sticky, outstanding.
// Build option: DDR_ARB_PLAYBACK_PRIO_EN gives requester 0 fixed priority.
module ddr_audio_arb
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rq0_valid,
  input  logic                       rq0_write,
  input  logic [ADDR_W-1:0]          rq0_addr,
  input  logic [DATA_W-1:0]          rq0_wdata,
  output logic                       rq0_ready,
  input  logic                       rq1_valid,
  input  logic                       rq1_write,
  input  logic [ADDR_W-1:0]          rq1_addr,
  input  logic [DATA_W-1:0]          rq1_wdata,
  output logic                       rq1_ready,
  output logic                       rsp0_valid,
  output logic                       rsp1_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic [DATA_W-1:0]          avm_writedata,
  input  logic                       avm_waitrequest,
  input  logic                       avm_readdatavalid,
  input  logic [DATA_W-1:0]          avm_readdata,
  output logic                       err_sticky,
  output logic [$clog2(MAX_OUT):0]   outstanding
);

  arb_state_e state_q;
  arb_state_e state_d;
  req_id_t    grant_q;
  req_id_t    last_q;
  req_id_t    win;
  req_id_t    fifo_dout;
  logic       e0;
  logic       e1;
  logic       do_grant;
  logic       accept;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  // reads need a free ID slot; writes never do
  assign e0 = rq0_valid & (rq0_write | ~fifo_full);
  assign e1 = rq1_valid & (rq1_write | ~fifo_full);

`ifdef DDR_ARB_PLAYBACK_PRIO_EN
  assign win = e0 ? 1'b0 : 1'b1;
`else
  assign win = (e0 & e1) ? ~last_q : e1;
`endif

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (e0 | e1) begin
          do_grant = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!avm_waitrequest) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = (state_q == ST_BUSY) & ~avm_waitrequest;
  assign rq0_ready = accept & (grant_q == 1'b0);
  assign rq1_ready = accept & (grant_q == 1'b1);

  assign fifo_push  = accept & avm_read;
  assign fifo_pop   = avm_readdatavalid & ~fifo_empty;
  assign rsp0_valid = fifo_pop & (fifo_dout == 1'b0);
  assign rsp1_valid = fifo_pop & (fifo_dout == 1'b1);
  assign rsp_data   = avm_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_grant) begin
        grant_q       <= win;
        last_q        <= win;
        avm_address   <= win ? rq1_addr  : rq0_addr;
        avm_writedata <= win ? rq1_wdata : rq0_wdata;
        avm_write     <= win ? rq1_write : rq0_write;
        avm_read      <= win ? ~rq1_write : ~rq0_write;
      end else if (accept) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end
      // return with nothing outstanding is dropped and flagged
      if (avm_readdatavalid & fifo_empty) err_sticky <= 1'b1;
    end
  end

  ddr_arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (grant_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_ddr_audio_arb.sv
// Self-checking bench for ddr_audio_arb.
// Directed scenarios plus random traffic against a transaction model.
module tb_ddr_audio_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    rqv = '0;
  logic [1:0]    rqw = '0;
  logic [AW-1:0] rqa [2];
  logic [DW-1:0] rqd [2];
  logic          rq0_ready, rq1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic          avm_readdatavalid = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          err_sticky;
  logic [2:0]    outstanding;

  always #5 clk = ~clk;

  ddr_audio_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rqv[0]), .rq0_write(rqw[0]),
    .rq0_addr(rqa[0]), .rq0_wdata(rqd[0]), .rq0_ready(rq0_ready),
    .rq1_valid(rqv[1]), .rq1_write(rqw[1]),
    .rq1_addr(rqa[1]), .rq1_wdata(rqd[1]), .rq1_ready(rq1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .err_sticky(err_sticky), .outstanding(outstanding)
  );

  int n_chk = 0;
  int n_fail = 0;

  // transaction-level model
  bit            m_busy;
  bit            m_g;
  bit            m_last;
  bit            m_cw;
  logic [AW-1:0] m_ca;
  logic [DW-1:0] m_cd;
  bit            m_err;
  bit            q[$];
  bit            glog[$];
  int            mode;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick(input bit e0, input bit e1);
    if (e0 && e1) begin
`ifdef DDR_ARB_PLAYBACK_PRIO_EN
      return 1'b0;
`else
      return !m_last;
`endif
    end
    return e0 ? 1'b0 : 1'b1;
  endfunction

  task automatic newcmd(input int id);
    rqa[id] = $urandom;
    rqd[id] = $urandom;
    case (mode)
      0: begin
        rqv[id] = ($urandom_range(0, 3) != 0);
        rqw[id] = $urandom_range(0, 1);
      end
      1: begin
        rqv[id] = 1'b1;
        rqw[id] = 1'b0;
      end
      default: rqv[id] = 1'b0;
    endcase
  endtask

  // one clock: entered and left at a falling edge with inputs set
  task automatic cycle(input bit wt, input bit rdv,
                       input logic [DW-1:0] rd);
    int       sz;
    bit       e0, e1, w, acc, g;
    logic [1:0] er, es;
    avm_waitrequest   = wt;
    avm_readdatavalid = rdv;
    avm_readdata      = rd;
    #1;
    sz  = q.size();
    acc = 1'b0;
    g   = m_g;
    chk("outstanding", outstanding, sz);
    chk("err_sticky", err_sticky, m_err);
    chk("rd_wr_excl", avm_read & avm_write, 0);
    if (m_busy) begin
      chk("avm_read", avm_read, !m_cw);
      chk("avm_write", avm_write, m_cw);
      chk("avm_address", avm_address, m_ca);
      if (m_cw) chk("avm_writedata", avm_writedata, m_cd);
    end else begin
      chk("avm_idle", {avm_read, avm_write}, 0);
    end
    er = '0;
    if (m_busy && !wt) er[m_g] = 1'b1;
    chk("rq_ready", {rq1_ready, rq0_ready}, er);
    es = '0;
    if (rdv) begin
      if (sz > 0) begin
        w = q.pop_front();
        es[w] = 1'b1;
        chk("rsp_data", rsp_data, rd);
      end else begin
        m_err = 1'b1;
      end
    end
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, es);
    if (m_busy) begin
      if (!wt) begin
        if (!m_cw) q.push_back(m_g);
        m_busy = 1'b0;
        acc = 1'b1;
      end
    end else begin
      e0 = rqv[0] && (rqw[0] || sz < MO);
      e1 = rqv[1] && (rqw[1] || sz < MO);
      if (e0 || e1) begin
        w = pick(e0, e1);
        m_busy = 1'b1;
        m_g = w;
        m_last = w;
        m_cw = rqw[w];
        m_ca = rqa[w];
        m_cd = rqd[w];
        glog.push_back(w);
      end
    end
    @(negedge clk);
    if (acc) newcmd(g);
    if (mode == 0) begin
      for (int i = 0; i < 2; i++) if (!rqv[i]) newcmd(i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    #1;
    chk("rst_avm_rw", {avm_read, avm_write}, 0);
    chk("rst_avm_addr", avm_address, 0);
    chk("rst_avm_wdata", avm_writedata, 0);
    chk("rst_ready", {rq1_ready, rq0_ready}, 0);
    chk("rst_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_outstanding", outstanding, 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    glog.delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_err = 1'b0;
  endtask

  task automatic rand_rdv(output bit b);
    b = (q.size() > 0) && ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    bit b;
    int guard;
    rqa[0] = '0; rqa[1] = '0; rqd[0] = '0; rqd[1] = '0;
    mode = 2;
    @(negedge clk);
    do_reset();

    // single write from playback
    rqv = 2'b01; rqw = 2'b01;
    rqa[0] = 32'h100; rqd[0] = 32'hA5A5A5A5;
    repeat (3) cycle(0, 0, '0);

    // reset while a read waits in BUSY
    rqv = 2'b10; rqw = 2'b00; rqa[1] = 32'h200;
    cycle(0, 0, '0);
    cycle(1, 0, '0);
    do_reset();

    // both requesters reading continuously
    mode = 1;
    newcmd(0); newcmd(1);
    for (int i = 0; i < 24; i++) begin
      rand_rdv(b);
      cycle(0, b, $urandom);
    end
    chk("rr_enough_grants", glog.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
`ifdef DDR_ARB_PLAYBACK_PRIO_EN
      chk("grant_order", glog[k], 0);
`else
      chk("grant_order", glog[k], k % 2);
`endif
    end

    // read held off by waitrequest for 5 cycles
    mode = 2;
    do_reset();
    rqv = 2'b10; rqw = 2'b00; rqa[1] = 32'h340;
    cycle(0, 0, '0);
    repeat (5) cycle(1, 0, '0);
    cycle(0, 0, '0);
    cycle(0, 0, '0);

    // fill the ID FIFO, then a write still gets through
    do_reset();
    mode = 1;
    newcmd(0);
    rqv[1] = 1'b0;
    repeat (8) cycle(0, 0, '0);
    chk("outstanding_full", outstanding, 4);
    repeat (3) cycle(0, 0, '0);
    mode = 2;
    rqv[0] = 1'b0;
    rqv[1] = 1'b1; rqw[1] = 1'b1;
    rqa[1] = 32'h480; rqd[1] = 32'h5A5A0001;
    repeat (3) cycle(0, 0, '0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      cycle(0, 1, $urandom);
      guard++;
    end
    chk("drain_done", q.size(), 0);

    // in-order returns to capture then playback
    do_reset();
    rqv = 2'b10; rqw = 2'b00; rqa[1] = 32'h10;
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    rqv[0] = 1'b1; rqw[0] = 1'b0; rqa[0] = 32'h20;
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    cycle(0, 1, 32'h11);
    cycle(0, 1, 32'h22);
    cycle(0, 0, '0);

    // return with nothing outstanding
    do_reset();
    rqv = 2'b00;
    cycle(0, 1, 32'hDEAD);
    repeat (3) cycle(0, 0, '0);
    chk("err_held", err_sticky, 1);
    do_reset();

    // random mixed traffic
    mode = 0;
    newcmd(0); newcmd(1);
    for (int i = 0; i < 400; i++) begin
      b = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 3) == 0, b, $urandom);
    end
    mode = 2;
    rqv = 2'b00;
    guard = 0;
    while ((q.size() > 0 || m_busy) && guard < 40) begin
      cycle(0, q.size() > 0, $urandom);
      guard++;
    end
    chk("final_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_audio_arb.md
DDR_AUDIO_ARB -- requirements
Module: ddr_audio_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width of requesters and memory port.
REQ-002 SHALL have parameter DATA_W, default 32: data width of requesters and memory port.
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum outstanding reads, a power of two with value 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports rq0_valid/rq1_valid, input, 1 bit each: command request from requester 0 (playback) and requester 1 (capture).
REQ-007 SHALL have ports rqN_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have ports rqN_addr, input, ADDR_W bits, and rqN_wdata, input, DATA_W bits: command address and write data.
REQ-009 SHALL have ports rqN_ready, output, 1 bit: one-cycle pulse meaning the command was accepted by memory.
REQ-010 SHALL have ports rspN_valid, output, 1 bit, and rsp_data, output, DATA_W bits: read return to requester N.
REQ-011 SHALL have Avalon-MM master ports avm_address (ADDR_W), avm_read, avm_write, avm_writedata (DATA_W) as outputs.
REQ-012 SHALL have avm_waitrequest, avm_readdatavalid and avm_readdata (DATA_W) as inputs.
REQ-013 SHALL have ports err_sticky, output, 1 bit, and outstanding, output, $clog2(MAX_OUT)+1 bits: status.

Function
REQ-014 SHALL implement FSM IDLE/BUSY; in IDLE with an eligible request, latch winner's cmd into avm_* regs, go BUSY next cycle.
REQ-015 SHALL treat a request as eligible when rqN_valid=1 and (rqN_write=1 or outstanding<MAX_OUT).
REQ-016 SHALL, in BUSY, hold avm_address/avm_writedata/avm_read/avm_write stable while avm_waitrequest=1.
REQ-017 SHALL, in BUSY with avm_waitrequest=0, pulse rqN_ready of granted requester combinationally that cycle, drop avm_read/write next cycle, return IDLE.
REQ-018 SHALL sustain one command per 2 cycles maximum; grant-to-avm_read/write latency exactly 1 cycle.
REQ-019 SHALL arbitrate round-robin: when both eligible, the requester not granted last wins; a lone eligible requester always wins.
REQ-020 SHALL push granted requester ID into an ID FIFO (depth MAX_OUT) on each accepted read.
REQ-021 SHALL pop the ID FIFO on avm_readdatavalid and assert rspN_valid for exactly that cycle, combinationally, with rsp_data=avm_readdata.
REQ-022 SHALL, on simultaneous accept-read and readdatavalid, push and pop in the same cycle with outstanding unchanged.
REQ-023 SHALL, on avm_readdatavalid with FIFO empty, drop the data, assert no rspN_valid, and set err_sticky (cleared only by reset).
REQ-024 SHALL never assert avm_read and avm_write together; rqN inputs ignored while not in IDLE.

Reset
REQ-025 SHALL on reset force IDLE, avm_read=avm_write=0, avm_address=avm_writedata=0, rqN_ready=rspN_valid=0, err_sticky=0, outstanding=0, FIFO empty.
REQ-026 SHALL reset last-grant to 1 so requester 0 wins the first tie.
REQ-027 SHALL abandon an in-flight command on reset mid-BUSY, with no rqN_ready issued.

Configuration
REQ-028 SHALL, with DDR_ARB_PLAYBACK_PRIO_EN defined, give requester 0 fixed priority over requester 1 instead of round-robin; without it, REQ-019 applies.

Structure
REQ-029 SHALL place FSM state enum, requester-ID type and default parameter constants in shared package ddr_arb_pkg.
REQ-030 SHALL implement the ID FIFO as sub-module ddr_arb_id_fifo (parameterised depth, 1-bit payload, full/empty/count).

Verification
REQ-031 SHALL cover: reset deasserted, rq0 write addr 0x100 data 0xA5A5A5A5, waitrequest=0 -> avm_write high 1 cycle with those values, rq0_ready pulse.
REQ-032 SHALL cover: both rq0/rq1 read continuously -> grants alternate 0,1,0,1 (first 0); with DDR_ARB_PLAYBACK_PRIO_EN -> always 0.
REQ-033 SHALL cover: waitrequest held 5 cycles on a read -> avm_* stable 5 cycles, single rq ready pulse on cycle 6.
REQ-034 SHALL cover: 4 reads accepted without readdatavalid (MAX_OUT=4) -> 5th read stalls, write from other requester still granted; outstanding=4.
REQ-035 SHALL cover: returns in order for IDs 1,0 with data 0x11,0x22 -> rsp1_valid with 0x11 then rsp0_valid with 0x22.
REQ-036 SHALL cover: spurious readdatavalid with empty FIFO -> no rspN_valid, err_sticky=1 until reset.
